// File: rtl/group_serial_subtractor_pkg.sv
// Shared types and default sizes for the group-serial subtractor.
package group_serial_subtractor_pkg;

   // Default operand width and slice width (shared with the group-prefix adder).
   localparam int DEF_INPUTSIZE = 32;
   localparam int DEF_GROUPSIZE = 4;

   // FSM states; encodings kept identical to the legacy GSS_* values.
   typedef enum logic [1:0] {
      GSS_IDLE = 2'd0,
      GSS_SUB  = 2'd1,
      GSS_NEG  = 2'd2,
      GSS_DONE = 2'd3
   } gss_state_t;

endpackage : group_serial_subtractor_pkg

// File: rtl/group_serial_subtractor_slice.sv
// One GROUPSIZE-bit borrow-ripple slice: d = a - b - bin, bout = borrow out.
module group_borrow_slice #(
   parameter int Groupsize = 4
) (
   input  logic [Groupsize-1:0] a,
   input  logic [Groupsize-1:0] b,
   input  logic                 bin,
   output logic [Groupsize-1:0] d,
   output logic                 bout
);

   logic [Groupsize:0] full;

   // Extend by one bit so the wrap-around of the slice subtraction lands in the borrow bit.
   always_comb begin
      full = {1'b0, a} - {1'b0, b} - {{Groupsize{1'b0}}, bin};
      d    = full[Groupsize-1:0];
      bout = full[Groupsize];
   end

endmodule : group_borrow_slice

// File: rtl/group_serial_subtractor.sv
// Multi-cycle unsigned subtractor: A - B - bin one slice per cycle, sign-magnitude result.
module group_serial_subtractor
   import group_serial_subtractor_pkg::*;
#(
   parameter int INPUTSIZE = DEF_INPUTSIZE,
   parameter int GROUPSIZE = DEF_GROUPSIZE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INPUTSIZE-1:0] a,
   input  logic [INPUTSIZE-1:0] b,
   input  logic                 bin,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 diff_sign,
   output logic [INPUTSIZE:0]   diff_mag
);

   localparam int NGROUPS = INPUTSIZE / GROUPSIZE;
   localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
   localparam logic [GW-1:0]      LAST_GRP = GW'(NGROUPS - 1);
   localparam logic [INPUTSIZE:0] MAG_FULL = {1'b1, {INPUTSIZE{1'b0}}};

   generate
      if (INPUTSIZE % GROUPSIZE != 0) begin : g_size_check
         $fatal(1, "group_serial_subtractor: INPUTSIZE must be a multiple of GROUPSIZE");
      end
   endgenerate

   gss_state_t state, state_next;

   logic [INPUTSIZE-1:0]           a_reg;
   logic [INPUTSIZE-1:0]           b_reg;
   logic [INPUTSIZE-1:0]           raw;
   logic [INPUTSIZE+GROUPSIZE-1:0] raw_cat;
   logic                           borrow_reg;
   logic [GW-1:0]                  grp;
   logic [GROUPSIZE-1:0]           slice_d;
   logic                           slice_bout;
   logic                           accept;

   // Operands shift right one slice per cycle, so the single slice always sees
   // group grp in the low bits; raw fills from the top and is complete after NGROUPS shifts.
   group_borrow_slice #(.Groupsize(GROUPSIZE)) u_slice (
      .a    (a_reg[GROUPSIZE-1:0]),
      .b    (b_reg[GROUPSIZE-1:0]),
      .bin  (borrow_reg),
      .d    (slice_d),
      .bout (slice_bout)
   );

   assign raw_cat   = {slice_d, raw};
   assign accept    = in_valid && in_ready;
   // Gated by rst_n so the block never advertises readiness while held in reset.
   assign in_ready  = rst_n && (state == GSS_IDLE);
   assign out_valid = (state == GSS_DONE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= GSS_IDLE;
      else        state <= state_next;
   end

   // Next-state logic: accept, NGROUPS slice cycles, one sign fix-up cycle, hold until retired.
   always_comb begin
      state_next = state;
      case (state)
         GSS_IDLE: if (accept)          state_next = GSS_SUB;
         GSS_SUB:  if (grp == LAST_GRP) state_next = GSS_NEG;
         GSS_NEG:                       state_next = GSS_DONE;
         GSS_DONE: if (out_ready)       state_next = GSS_IDLE;
         default:                       state_next = GSS_IDLE;
      endcase
   end

   // Datapath: operand capture, slice ripple, and sign-magnitude conversion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg      <= '0;
         b_reg      <= '0;
         raw        <= '0;
         borrow_reg <= 1'b0;
         grp        <= '0;
         diff_sign  <= 1'b0;
         diff_mag   <= '0;
      end else begin
         case (state)
            GSS_IDLE: begin
               if (accept) begin
                  a_reg      <= a;
                  b_reg      <= b;
                  borrow_reg <= bin;
                  grp        <= '0;
               end
            end
            GSS_SUB: begin
               a_reg      <= a_reg >> GROUPSIZE;
               b_reg      <= b_reg >> GROUPSIZE;
               raw        <= raw_cat[INPUTSIZE+GROUPSIZE-1:GROUPSIZE];
               borrow_reg <= slice_bout;
               grp        <= grp + 1'b1;
            end
            GSS_NEG: begin
               if (borrow_reg) begin
                  diff_sign <= 1'b1;
                  diff_mag  <= MAG_FULL - {1'b0, raw};
               end else begin
                  diff_sign <= 1'b0;
                  diff_mag  <= {1'b0, raw};
               end
            end
            default: ;
         endcase
      end
   end

endmodule : group_serial_subtractor
